// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Round-robin on conflict; one access in flight at a time.
module mem_port_arbiter #(
    parameter int WORDSIZE   = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [WORDSIZE-1:0]   if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORDSIZE-1:0]   d_wdata,
    output logic                  d_ack,
    output logic [WORDSIZE-1:0]   d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORDSIZE-1:0]   mem_wdata,
    input  logic [WORDSIZE-1:0]   mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t state;
    logic   grant_d;

    // owner doubles as last_owner: on conflict the other requester wins.
    always_comb begin
        grant_d = d_req;
        if (if_req && d_req)
            grant_d = ~owner;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner     <= grant_d;
                        mem_req   <= 1'b1;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_we    <= grant_d & d_we;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner) begin
                            d_ack <= 1'b1;
                            // stores leave the load-data register untouched
                            if (!mem_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level
// model (grant choice, expected memory request fields, read-data registers).
module tb_mem_port_arbiter;

    localparam int W = 64;
    localparam int A = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [A-1:0] if_addr = '0, d_addr = '0;
    logic [W-1:0] d_wdata = '0, mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         if_ack, d_ack, mem_req, mem_we, busy, owner;
    logic [W-1:0] if_rdata, d_rdata, mem_wdata;
    logic [A-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           last_owner;
    logic [W-1:0] exp_if_rdata, exp_d_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORDSIZE(W), .ADDR_WIDTH(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_if_ack"}, if_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
    endtask

    task automatic do_reset();
        if_req = 0; d_req = 0; mem_ready = 0;
        rst_n = 0;
        #1;
        check_idle_outputs("rst");
        chk("rst_owner", owner, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        last_owner = 0; exp_if_rdata = '0; exp_d_rdata = '0;
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT is idle with at least one req high.
    // Serves exactly one transaction and returns at the negedge of the idle
    // cycle that follows the ack.
    task automatic serve(input int lat, input bit drop, input logic [W-1:0] rd);
        int           w;
        bit           win, we;
        logic [A-1:0] addr;
        logic [W-1:0] wd;
        win  = (if_req && d_req) ? !last_owner : d_req;
        we   = win && d_we;
        addr = win ? d_addr : if_addr;
        wd   = win ? d_wdata : '0;
        w = 0;
        while (!mem_req && w < 5) begin
            @(negedge clk);
            w++;
        end
        chk("grant_latency", w, 1);
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", mem_we, we);
        chk("mem_wdata", mem_wdata, wd);
        chk("owner", owner, win);
        chk("busy_access", busy, 1);
        if (drop) begin
            if (win) d_req = 0; else if_req = 0;
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("hold_mem_req", mem_req, 1);
            chk("hold_mem_addr", mem_addr, addr);
            chk("no_early_ack", if_ack | d_ack, 0);
        end
        mem_ready = 1; mem_rdata = rd;
        @(negedge clk);
        mem_ready = 0; mem_rdata = {$urandom, $urandom};
        if (!win) exp_if_rdata = rd;
        else if (!we) exp_d_rdata = rd;
        chk("if_ack", if_ack, !win);
        chk("d_ack", d_ack, win);
        chk("ack_mem_req", mem_req, 0);
        chk("ack_busy", busy, 1);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (win) d_req = 0; else if_req = 0;
        last_owner = win;
        @(negedge clk);
        check_idle_outputs("post_ack");
    endtask

    initial begin
        // 1. reset, then reset mid-access, then normal service
        do_reset();
        if_addr = 64'h40; if_req = 1;
        @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        rst_n = 0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1;
        last_owner = 0; exp_if_rdata = '0; exp_d_rdata = '0;
        serve(1, 0, 64'h1111);

        // 2. fetch alone
        if_addr = 64'h100; if_req = 1;
        serve(3, 0, 64'h13);
        chk("fetch_if_rdata", if_rdata, 64'h13);

        // 3. store leaves d_rdata alone
        d_we = 1; d_addr = 64'h2000; d_wdata = 64'hDEADBEEF; d_req = 1;
        serve(1, 0, 64'hBAD0BAD0);
        chk("store_d_rdata", d_rdata, 64'h0);

        // 4. conflicts after reset: data, fetch, then data again
        do_reset();
        if_addr = 64'h300; d_addr = 64'h4000; d_we = 0; d_wdata = 64'h55;
        if_req = 1; d_req = 1;
        serve(0, 0, 64'hD1);
        chk("conflict1_owner", last_owner, 1);
        serve(0, 0, 64'hF1);
        chk("conflict2_owner", last_owner, 0);
        if_req = 1; d_req = 1;
        serve(2, 0, 64'hD2);
        chk("conflict3_owner", last_owner, 1);
        serve(0, 0, 64'hF2);

        // 5. zero-wait memory, fetch held high: one ack per 3 cycles
        mem_ready = 1; mem_rdata = 64'h77; if_addr = 64'h500; if_req = 1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("zw_if_ack", if_ack, (k % 3) == 2);
            chk("zw_mem_req", mem_req, (k % 3) == 1);
            chk("zw_overlap", mem_req & if_ack, 0);
        end
        if_req = 0; mem_ready = 0;
        exp_if_rdata = 64'h77; last_owner = 0;
        @(negedge clk);
        chk("zw_if_rdata", if_rdata, 64'h77);

        // 6. spurious mem_ready while idle, then d_req dropped mid-access
        mem_ready = 1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("spurious");
        end
        mem_ready = 0;
        d_we = 0; d_addr = 64'h6000; d_req = 1;
        serve(2, 1, 64'hABCD);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!if_req && !d_req) begin
                int pick;
                pick = $urandom_range(0, 2);
                if (pick != 1) begin
                    if_addr = {$urandom, $urandom}; if_req = 1;
                end
                if (pick != 0) begin
                    d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
                    d_we = $urandom_range(0, 1); d_req = 1;
                end
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3) == 0, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
